// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate-generation stage: format codes and
// base-ISA opcodes.
package imm_gen_pkg;
    localparam int FMT_W = 3;
    typedef logic [FMT_W-1:0] fmt_t;

    localparam fmt_t FMT_NONE = 3'd0;
    localparam fmt_t FMT_I    = 3'd1;
    localparam fmt_t FMT_S    = 3'd2;
    localparam fmt_t FMT_B    = 3'd3;
    localparam fmt_t FMT_U    = 3'd4;
    localparam fmt_t FMT_J    = 3'd5;
    localparam fmt_t FMT_SH   = 3'd6;
    localparam fmt_t FMT_R    = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word to {imm, fmt, unknown}.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_t            fmt_o,
    output logic            unknown_o
);
    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  op;
    logic [2:0]  f3;
    logic        is_shift;
    logic [31:0] imm32;

    assign op       = instr_i[6:0];
    assign f3       = instr_i[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Every format is built as a sign-extended 32-bit value, then widened once.
    always_comb begin
        imm32     = '0;
        fmt_o     = FMT_NONE;
        unknown_o = 1'b0;
        case (op)
            OP_LOAD, OP_JALR: begin
                fmt_o = FMT_I;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_IMM, OP_IMM32: begin
                if (op == OP_IMM32 && !RV64) begin
                    unknown_o = 1'b1;
                end else if (is_shift) begin
                    fmt_o = FMT_SH;
                    imm32 = (RV64 && op == OP_IMM) ? {26'b0, instr_i[25:20]}
                                                   : {27'b0, instr_i[24:20]};
                end else begin
                    fmt_o = FMT_I;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OP_STORE: begin
                fmt_o = FMT_S;
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                fmt_o = FMT_B;
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_o = FMT_U;
                imm32 = {instr_i[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt_o = FMT_J;
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            end
            OP_REG, OP_REG32: begin
                if (op == OP_REG32 && !RV64) unknown_o = 1'b1;
                else                         fmt_o     = FMT_R;
            end
            default: unknown_o = 1'b1;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decoder feeding a 2-entry skid FIFO,
// plus a saturating counter of accepted unknown opcodes.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [FMT_W-1:0] out_fmt,
    output logic             out_unknown,
    output logic [CNT_W-1:0] unknown_cnt
);
    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_unk;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .unknown_o (dec_unk)
    );

    logic [XLEN-1:0]  imm_q [2];
    fmt_t             fmt_q [2];
    logic [1:0]       unk_q;
    logic             head_q, tail_q;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push, pop;

    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 2'd1;
        else if (pop && !push) count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= FMT_NONE;
            end
            unk_q      <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            if (push) begin
                imm_q[tail_q] <= dec_imm;
                fmt_q[tail_q] <= dec_fmt;
                unk_q[tail_q] <= dec_unk;
                tail_q        <= ~tail_q;
                if (dec_unk && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
            if (pop) head_q <= ~head_q;
            count_q    <= count_d;
            // Registered so the producer never sees a path from out_ready.
            in_ready_q <= (count_d != 2'd2);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_imm     = imm_q[head_q];
    assign out_fmt     = fmt_q[head_q];
    assign out_unknown = unk_q[head_q];
    assign unknown_cnt = cnt_q;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an XLEN=64 and an XLEN=32 (2-bit counter) instance
// share one stimulus stream and are checked against a reference decoder.
module tb_imm_gen_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic        out_ready = 1'b0;

    logic        rdy64, ov64, unk64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [15:0] cnt64;
    logic        rdy32, ov32, unk32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [1:0]  cnt32;

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];
    int mc64 = 0;
    int mc32 = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_unknown(unk64), .unknown_cnt(cnt64)
    );

    imm_gen_stage #(.XLEN(32), .CNT_W(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_unknown(unk32), .unknown_cnt(cnt32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate rules written as arithmetic on a sign-extended word.
    function automatic void ref_dec(input logic [31:0] ins, input int xl,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic unk);
        longint v, s12, s20, s25, s31;
        logic [6:0] op;
        logic [2:0] f3;
        bit rv64, is_imm;
        op = ins[6:0];
        f3 = ins[14:12];
        rv64 = (xl == 64);
        v = longint'($signed(ins));
        s12 = v >>> 12;
        s20 = v >>> 20;
        s25 = v >>> 25;
        s31 = v >>> 31;
        imm = 64'h0;
        fmt = 3'd0;
        unk = 1'b0;
        is_imm = (op == 7'h13) || (op == 7'h1B && rv64);
        if (is_imm && (f3 == 3'd1 || f3 == 3'd5)) begin
            fmt = 3'd6;
            imm = (op == 7'h13 && rv64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
        end else if (is_imm || op == 7'h03 || op == 7'h67) begin
            fmt = 3'd1; imm = s20;
        end else if (op == 7'h23) begin
            fmt = 3'd2; imm = s25 * 32 + 64'(ins[11:7]);
        end else if (op == 7'h63) begin
            fmt = 3'd3;
            imm = s31 * 4096 + 64'(ins[7]) * 2048 + 64'(ins[30:25]) * 32 + 64'(ins[11:8]) * 2;
        end else if (op == 7'h37 || op == 7'h17) begin
            fmt = 3'd4; imm = s12 * 4096;
        end else if (op == 7'h6F) begin
            fmt = 3'd5;
            imm = s31 * 1048576 + 64'(ins[19:12]) * 4096 + 64'(ins[20]) * 2048 + 64'(ins[30:21]) * 2;
        end else if (op == 7'h33 || (op == 7'h3B && rv64)) begin
            fmt = 3'd7;
        end else begin
            unk = 1'b1;
        end
        if (!rv64) imm[63:32] = 32'h0;
    endfunction

    task automatic check_state();
        logic [63:0] ei;
        logic [2:0]  ef;
        logic        eu;
        chk("in_ready64", 64'(rdy64), 64'(q.size() < 2));
        chk("in_ready32", 64'(rdy32), 64'(q.size() < 2));
        chk("out_valid64", 64'(ov64), 64'(q.size() != 0));
        chk("out_valid32", 64'(ov32), 64'(q.size() != 0));
        chk("unknown_cnt64", 64'(cnt64), 64'(mc64));
        chk("unknown_cnt32", 64'(cnt32), 64'(mc32));
        if (q.size() != 0) begin
            ref_dec(q[0], 64, ei, ef, eu);
            chk("out_imm64", imm64, ei);
            chk("out_fmt64", 64'(fmt64), 64'(ef));
            chk("out_unknown64", 64'(unk64), 64'(eu));
            ref_dec(q[0], 32, ei, ef, eu);
            chk("out_imm32", 64'(imm32), ei);
            chk("out_fmt32", 64'(fmt32), 64'(ef));
            chk("out_unknown32", 64'(unk32), 64'(eu));
        end
    endtask

    // Called at a falling edge; applies one cycle and re-checks the outputs.
    task automatic drive(input logic v, input logic [31:0] ins, input logic r, output bit acc);
        bit push, pop;
        logic [63:0] ei;
        logic [2:0]  ef;
        logic        eu;
        in_valid = v; in_instr = ins; out_ready = r;
        push = v && (q.size() < 2);
        pop  = r && (q.size() != 0);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(ins);
            ref_dec(ins, 64, ei, ef, eu);
            if (eu && mc64 < 65535) mc64++;
            ref_dec(ins, 32, ei, ef, eu);
            if (eu && mc32 < 3) mc32++;
        end
        acc = push;
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [63:0] i64; logic [2:0] f64; logic u64;
        logic [31:0] i32; logic [2:0] f32; logic u32;
    } vec_t;

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [12];
        logic [31:0] r;
        ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h00};
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    initial begin
        vec_t tbl [12];
        bit acc;
        logic v;
        logic [31:0] ins;

        tbl[0]  = '{32'h00000000, 64'h0,                3'd0, 1'b1, 32'h0,        3'd0, 1'b1};
        tbl[1]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 3'd1, 1'b0};
        tbl[2]  = '{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 32'hFFFFFFFC, 3'd2, 1'b0};
        tbl[3]  = '{32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0, 32'hFFFFFFF8, 3'd3, 1'b0};
        tbl[4]  = '{32'h0010006F, 64'h800,              3'd5, 1'b0, 32'h800,      3'd5, 1'b0};
        tbl[5]  = '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 32'h80000000, 3'd4, 1'b0};
        tbl[6]  = '{32'h03F09093, 64'd63,               3'd6, 1'b0, 32'd31,       3'd6, 1'b0};
        tbl[7]  = '{32'h4010D093, 64'd1,                3'd6, 1'b0, 32'd1,        3'd6, 1'b0};
        tbl[8]  = '{32'hFFF0009B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 32'h0,        3'd0, 1'b1};
        tbl[9]  = '{32'h00000033, 64'h0,                3'd7, 1'b0, 32'h0,        3'd7, 1'b0};
        tbl[10] = '{32'h0000003B, 64'h0,                3'd7, 1'b0, 32'h0,        3'd0, 1'b1};
        tbl[11] = '{32'hFFFFFFFF, 64'h0,                3'd0, 1'b1, 32'h0,        3'd0, 1'b1};

        // Reset values while held in reset.
        #12;
        chk("rst_out_valid", 64'({ov64, ov32}), 64'(0));
        chk("rst_in_ready", 64'({rdy64, rdy32}), 64'(3));
        chk("rst_out_imm", imm64 | 64'(imm32), 64'(0));
        chk("rst_out_fmt", 64'({fmt64, fmt32}), 64'(0));
        chk("rst_unknown", 64'({unk64, unk32, cnt64, cnt32}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        check_state();

        // Table vectors, streamed at full rate.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].ins, 1'b1, acc);
            chk("tbl_valid", 64'({ov64, ov32}), 64'(3));
            chk("tbl_imm64", imm64, tbl[i].i64);
            chk("tbl_fmt64", 64'(fmt64), 64'(tbl[i].f64));
            chk("tbl_unk64", 64'(unk64), 64'(tbl[i].u64));
            chk("tbl_imm32", 64'(imm32), 64'(tbl[i].i32));
            chk("tbl_fmt32", 64'(fmt32), 64'(tbl[i].f32));
            chk("tbl_unk32", 64'(unk32), 64'(tbl[i].u32));
            if (i == 0) chk("first_unknown_cnt", 64'(cnt64), 64'(1));
        end
        chk("cnt32_saturated", 64'(cnt32), 64'(3));
        chk("cnt64_total", 64'(cnt64), 64'(2));
        drive(1'b0, 32'h0, 1'b1, acc);

        // Backpressure: three back-to-back pushes with the consumer stalled.
        drive(1'b1, 32'hFFF00093, 1'b0, acc);
        drive(1'b1, 32'h800000B7, 1'b0, acc);
        chk("bp_in_ready_low", 64'({rdy64, rdy32}), 64'(0));
        drive(1'b1, 32'h0010006F, 1'b0, acc);
        chk("bp_third_held", 64'(acc), 64'(0));
        drive(1'b1, 32'h0010006F, 1'b0, acc);
        chk("bp_head_stable", imm64, 64'hFFFFFFFFFFFFFFFF);
        drive(1'b1, 32'h0010006F, 1'b1, acc);
        chk("bp_second_out", imm64, 64'hFFFFFFFF80000000);
        chk("bp_ready_back", 64'(rdy64), 64'(1));
        drive(1'b1, 32'h0010006F, 1'b1, acc);
        chk("bp_third_out", imm64, 64'h800);
        drive(1'b0, 32'h0, 1'b1, acc);
        chk("bp_drained", 64'(ov64), 64'(0));

        // Randomized traffic; producer holds its word until accepted.
        v = 1'b0; ins = 32'h0; acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!v || acc) begin
                v = ($urandom_range(0, 3) != 0);
                ins = rnd_instr();
            end
            drive(v, ins, ($urandom_range(0, 2) != 0), acc);
        end

        // Asynchronous reset with two entries buffered.
        drive(1'b0, 32'h0, 1'b1, acc);
        drive(1'b0, 32'h0, 1'b1, acc);
        drive(1'b1, 32'h00000000, 1'b0, acc);
        drive(1'b1, 32'h00000000, 1'b0, acc);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'({ov64, ov32}), 64'(0));
        chk("arst_in_ready", 64'({rdy64, rdy32}), 64'(3));
        chk("arst_cnt", 64'({cnt64, cnt32}), 64'(0));
        chk("arst_outputs", imm64 | 64'(imm32) | 64'({fmt64, fmt32, unk64, unk32}), 64'(0));
        q.delete();
        mc64 = 0;
        mc32 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h0010006F, 1'b1, acc);
        chk("post_rst_first_push", imm64, 64'h800);
        drive(1'b0, 32'h0, 1'b1, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
